// File: rtl/fetch_if.sv
// Fetch-stage bus: stall/cflag control, ROM read port and the D_BUS pipeline register
// presented to the execute stage.
interface fetch_if #(parameter int PC_WIDTH = 4);
  logic                stall;
  logic                cflag;
  logic [7:0]          rom_data;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [7:0]          D_BUS;
  logic [PC_WIDTH-1:0] pc;
  logic                halted;

  modport master (input stall, cflag, rom_data, output rom_addr, D_BUS, pc, halted);
  modport slave  (output stall, cflag, rom_data, input rom_addr, D_BUS, pc, halted);
endinterface

// File: rtl/fetch_stage.sv
// Pipeline stage 1: program counter, ROM fetch into D_BUS, JMP/JNC resolution with a
// single squash bubble, HALT state and stall freeze.
module fetch_stage #(
  parameter int         PC_WIDTH = 4,
  parameter logic [7:0] NOP_INSN = 8'hC0,
  parameter logic [3:0] OP_JMP   = 4'hF,
  parameter logic [3:0] OP_JNC   = 4'hE,
  parameter logic [3:0] OP_HALT  = 4'hD
) (
  input logic     clock,
  input logic     reset,
  fetch_if.master bus
);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]          state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          d_q;
  logic                halted_q;
  logic [3:0]          op;
  logic                take_jump;
  logic [PC_WIDTH-1:0] jump_tgt;

  // Decode acts on the instruction already sitting on D_BUS, not the byte being fetched.
  assign op        = d_q[7:4];
  assign take_jump = (op == OP_JMP) || ((op == OP_JNC) && !bus.cflag);
  assign jump_tgt  = PC_WIDTH'(d_q[3:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      d_q      <= NOP_INSN;
      state    <= ST_RUN;
      halted_q <= 1'b0;
    end else if (state == ST_RUN && !bus.stall) begin
      if (op == OP_HALT) begin
        d_q      <= NOP_INSN;
        state    <= ST_HALT;
        halted_q <= 1'b1;
      end else if (take_jump) begin
        // The byte fetched at the old pc is wrong-path; replace it with a bubble.
        pc_q <= jump_tgt;
        d_q  <= NOP_INSN;
      end else begin
        pc_q <= pc_q + 1'b1;
        d_q  <= bus.rom_data;
      end
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.pc       = pc_q;
  assign bus.D_BUS    = d_q;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes model predictions, a negedge monitor
// pops and compares pc, rom_addr, D_BUS and halted.
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_if bus ();
  fetch_stage dut (.clock(clock), .reset(reset), .bus(bus.master));

  logic [7:0] rom [16];
  assign bus.rom_data = rom[bus.rom_addr];

  typedef struct {
    int         cyc;
    logic [3:0] pc;
    logic [7:0] d;
    logic       h;
  } exp_t;
  exp_t q[$];

  int edge_cnt = 0;
  int errors   = 0;
  int checks   = 0;

  // Instruction-level reference state
  logic [3:0] mpc;
  logic [7:0] md;
  logic       mh;

  task automatic chk(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clock) edge_cnt++;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      exp_t e;
      e = q.pop_front();
      chk("pc",       e.cyc, 8'(bus.pc),       8'(e.pc));
      chk("rom_addr", e.cyc, 8'(bus.rom_addr), 8'(e.pc));
      chk("d_bus",    e.cyc, bus.D_BUS,        e.d);
      chk("halted",   e.cyc, 8'(bus.halted),   8'(e.h));
    end
  end

  // One cycle: apply inputs, advance the reference by the instruction rules, queue the result.
  task automatic step(input logic rst, input logic st, input logic cf);
    logic [3:0] op;
    reset     = rst;
    bus.stall = st;
    bus.cflag = cf;
    op = md[7:4];
    if (rst) begin
      mpc = 4'd0; md = 8'hC0; mh = 1'b0;
    end else if (!mh && !st) begin
      if (op == 4'hD) begin
        md = 8'hC0; mh = 1'b1;
      end else if (op == 4'hF || (op == 4'hE && !cf)) begin
        mpc = md[3:0]; md = 8'hC0;
      end else begin
        md = rom[mpc]; mpc = mpc + 4'd1;
      end
    end
    q.push_back('{edge_cnt + 1, mpc, md, mh});
    @(posedge clock);
    #1;
  endtask

  task automatic rom_inc();
    for (int i = 0; i < 16; i++) rom[i] = 8'(i);
  endtask

  task automatic run_until_d(input logic [7:0] target);
    for (int i = 0; i < 20 && md != target; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; bus.stall = 1'b0; bus.cflag = 1'b0;
    mpc = 4'd0; md = 8'hC0; mh = 1'b0;
    rom_inc();
    @(posedge clock); #1;

    // Sequential fetch and pc wrap
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

    // Unconditional jump
    rom[3] = 8'hF8;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

    // JNC not taken, then taken
    rom_inc(); rom[2] = 8'hE6;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

    // Stall while a JMP sits on D_BUS
    rom_inc(); rom[3] = 8'hF8;
    step(1'b1, 1'b0, 1'b0);
    run_until_d(8'hF8);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Stalled JNC: cflag seen on the release cycle decides
    rom_inc(); rom[2] = 8'hE9;
    step(1'b1, 1'b0, 1'b0);
    run_until_d(8'hE9);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // HALT with stall toggling, then reset out of it
    rom_inc(); rom[5] = 8'hD0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset while a JMP is on D_BUS
    rom_inc(); rom[3] = 8'hF8;
    step(1'b1, 1'b0, 1'b0);
    run_until_d(8'hF8);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Randomized program with random stall/cflag and periodic reset
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++) begin
        int k;
        k = $urandom_range(0, 15);
        if (k < 2)       rom[i] = {4'hF, 4'($urandom)};
        else if (k < 4)  rom[i] = {4'hE, 4'($urandom)};
        else if (k == 4) rom[i] = {4'hD, 4'($urandom)};
        else             rom[i] = {4'($urandom_range(0, 12)), 4'($urandom)};
      end
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++)
        step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
    #6;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
